// File: rtl/lsu_pkg.sv
// Shared load/store codes, responder FSM states and byte-lane helpers for the
// LSU memory responder and its write buffer.
package lsu_pkg;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LB  = 3'b010;
    localparam logic [2:0] LD_LHU = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    // Buffer entry is {word address, byte enables, data}; the address part is
    // sized by the instantiating module.
    localparam int unsigned WB_BE_W      = 4;
    localparam int unsigned WB_DATA_W    = 32;
    localparam int unsigned WB_PAYLOAD_W = WB_BE_W + WB_DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_LREQ,
        S_LWAIT,
        S_LDONE
    } lsu_state_e;

    function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] a);
        case (st)
            ST_SH:   return a[1] ? 4'b1100 : 4'b0011;
            ST_SB:   return 4'b0001 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] d);
        case (st)
            ST_SH:   return {2{d[15:0]}};
            ST_SB:   return {4{d[7:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic load_misaligned(input logic [2:0] ld, input logic [1:0] a);
        case (ld)
            LD_LH, LD_LHU: return a[0];
            LD_LB, LD_LBU: return 1'b0;
            default:       return a != 2'b00;
        endcase
    endfunction

    function automatic logic store_misaligned(input logic [1:0] st, input logic [1:0] a);
        case (st)
            ST_SH:   return a[0];
            ST_SB:   return 1'b0;
            default: return a != 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] ld, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (ld)
            LD_LH:   return {{16{h[15]}}, h};
            LD_LHU:  return {16'h0000, h};
            LD_LB:   return {{24{b[7]}}, b};
            LD_LBU:  return {24'h000000, b};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/lsu_write_buffer.sv
// Store write buffer: synchronous FIFO of DEPTH entries with full/empty flags
// and a combinational head output.
module lsu_write_buffer
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side load/store responder: buffered stores, stalling loads behind a
// drain. Define LSU_PERF_CNT_EN to add the stall performance counters.
module lsu_mem_responder
    import lsu_pkg::*;
#(
    parameter int unsigned WB_DEPTH = 4,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        load,
    input  logic [1:0]        store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              lsu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_load_stall,
    output logic [31:0]       perf_wb_full_stall
`endif
);

    localparam int unsigned WA_W    = ADDR_W - 2;
    localparam int unsigned ENTRY_W = WA_W + WB_PAYLOAD_W;

    lsu_state_e       state;
    lsu_state_e       state_nxt;
    logic             ld_mis;
    logic             st_mis;
    logic             err_now;
    logic             load_valid;
    logic             store_valid;
    logic             wb_push;
    logic             wb_pop;
    logic             wb_full;
    logic             wb_empty;
    logic [ENTRY_W-1:0] wb_head;
    logic             rd_issue;
    logic             wr_issue;
    logic             stall_load;
    logic             stall_full;

    assign ld_mis      = load_misaligned(load, addr[1:0]);
    assign st_mis      = store_misaligned(store, addr[1:0]);
    assign err_now     = (memRead & memWrite) | (memRead & ld_mis) | (memWrite & st_mis);
    assign load_valid  = memRead & ~memWrite & ~ld_mis;
    assign store_valid = memWrite & ~memRead & ~st_mis;
    assign wb_push     = store_valid & ~wb_full;
    assign wb_pop      = wr_issue & mem_ack;
    assign stall_full  = store_valid & wb_full;
    // Gated so a request held through reset cannot raise stall.
    assign stall       = rst_n & (stall_load | stall_full);

    lsu_write_buffer #(
        .DEPTH (WB_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wb (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wb_push),
        .push_data ({addr[ADDR_W-1:2], store_be(store, addr[1:0]), store_data(store, wdata)}),
        .pop       (wb_pop),
        .head      (wb_head),
        .full      (wb_full),
        .empty     (wb_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_issue   = 1'b0;
        wr_issue   = 1'b0;
        stall_load = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        case (state)
            S_IDLE: begin
                wr_issue = ~wb_empty;
                if (load_valid) begin
                    stall_load = 1'b1;
                    state_nxt  = wb_empty ? S_LREQ : S_DRAIN;
                end
            end
            S_DRAIN: begin
                wr_issue   = ~wb_empty;
                stall_load = 1'b1;
                if (wb_empty) begin
                    state_nxt = S_LREQ;
                end
            end
            S_LREQ, S_LWAIT: begin
                rd_issue   = 1'b1;
                stall_load = 1'b1;
                state_nxt  = mem_ack ? S_LDONE : S_LWAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
        // The held load address drives the port directly; the core keeps it stable while stalled.
        if (rd_issue) begin
            mem_req  = 1'b1;
            mem_addr = {addr[ADDR_W-1:2], 2'b00};
            mem_be   = '1;
        end else if (wr_issue) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {wb_head[ENTRY_W-1 -: WA_W], 2'b00};
            mem_be    = wb_head[WB_DATA_W +: WB_BE_W];
            mem_wdata = wb_head[WB_DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata   <= '0;
            lsu_err <= 1'b0;
        end else begin
            lsu_err <= err_now;
            if (rd_issue & mem_ack) begin
                rdata <= load_extract(load, addr[1:0], mem_rdata);
            end
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_load_stall    <= '0;
            perf_wb_full_stall <= '0;
        end else begin
            if (stall_load) begin
                perf_load_stall <= perf_load_stall + 32'd1;
            end
            if (stall_full) begin
                perf_wb_full_stall <= perf_wb_full_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: store lanes, load formatting, buffer
// full stall, drain ordering, error pulses and mid-transaction reset.
module tb_lsu_mem_responder;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [2:0]  load;
    logic [1:0]  store;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_load_stall;
    logic [31:0] perf_wb_full_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_responder #(
        .WB_DEPTH (4),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .load      (load),
        .store     (store),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .lsu_err   (lsu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef LSU_PERF_CNT_EN
        ,
        .perf_load_stall    (perf_load_stall),
        .perf_wb_full_stall (perf_wb_full_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        memRead = 1'b1; load = LD_LW; addr = 32'h20;
        repeat (2) tick();
        #1;
        checks++;
        if ({mem_req, mem_we, stall, lsu_err, mem_be} !== 8'h00) begin
            errors++; $display("FAIL reset_ctrl got %b exp 00000000", {mem_req, mem_we, stall, lsu_err, mem_be});
        end
        checks++;
        if ({rdata, mem_addr, mem_wdata} !== 96'h0) begin
            errors++; $display("FAIL reset_data got %h %h %h exp all zero", rdata, mem_addr, mem_wdata);
        end
        memRead = 1'b0; addr = '0;
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if ({mem_req, stall} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle got %b exp 00", {mem_req, stall});
        end
    endtask

    task automatic test_store_sb();
        tick();
        memWrite = 1'b1; store = ST_SB; addr = 32'h103; wdata = 32'h0000_00AB;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL sb_stall got %b exp 0", stall);
        end
        tick();
        memWrite = 1'b0; store = ST_SW; addr = '0; wdata = '0;
        for (int unsigned c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({mem_req, mem_we, mem_be} !== 6'b11_1000 || mem_addr !== 32'h100 || mem_wdata !== 32'hABAB_ABAB) begin
                errors++; $display("FAIL sb_port cyc%0d got req%b we%b be%b a%h d%h exp req1 we1 be1000 a00000100 dABABABAB",
                                   c, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
            end
            tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL sb_popped got req %b exp 0", mem_req);
        end
    endtask

    // Load with an empty buffer and same-cycle ack: IDLE, LREQ, LDONE.
    task automatic do_load(input logic [2:0] code, input logic [31:0] a,
                           input logic [31:0] word, input logic [31:0] exp);
        tick();
        memRead = 1'b1; load = code; addr = a;
        #1;
        checks++;
        if ({stall, mem_req} !== 2'b10) begin
            errors++; $display("FAIL ld_idle code%0d a%h got stall%b req%b exp stall1 req0", code, a, stall, mem_req);
        end
        tick();
        mem_ack = 1'b1; mem_rdata = word;
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, stall, lsu_err} !== 8'b1011_1110 || mem_addr !== {a[31:2], 2'b00}) begin
            errors++; $display("FAIL ld_req code%0d got req%b we%b be%b stall%b err%b a%h exp req1 we0 be1111 stall1 err0 a%h",
                               code, mem_req, mem_we, mem_be, stall, lsu_err, mem_addr, {a[31:2], 2'b00});
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || rdata !== exp) begin
            errors++; $display("FAIL ld_done code%0d a%h got stall%b rdata%h exp stall0 rdata%h", code, a, stall, rdata, exp);
        end
        tick();
        memRead = 1'b0; addr = '0;
    endtask

    task automatic test_load_formats();
        logic [2:0]  codes [8] = '{LD_LB, LD_LBU, LD_LHU, LD_LH, LD_LB, LD_LBU, LD_LH, LD_LW};
        logic [31:0] addrs [8] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100, 32'h102, 32'h104};
        logic [31:0] words [8] = '{32'h0080FF11, 32'h0080FF11, 32'h0080FF11, 32'h0080FF11,
                                   32'h0080FF11, 32'h0080FF11, 32'h0080FF11, 32'h12345678};
        logic [31:0] exps  [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00000080, 32'hFFFFFF11,
                                   32'hFFFFFFFF, 32'h00000011, 32'h00000080, 32'h12345678};
        for (int unsigned i = 0; i < 8; i++) begin
            do_load(codes[i], addrs[i], words[i], exps[i]);
        end
    endtask

    task automatic test_wb_full();
        tick();
        for (int unsigned i = 0; i < 5; i++) begin
            memWrite = 1'b1; store = ST_SW; addr = 32'h40 + 4 * i; wdata = 32'hA0 + i;
            #1;
            checks++;
            if (stall !== (i == 4)) begin
                errors++; $display("FAIL wbf_store%0d_stall got %b exp %b", i + 1, stall, i == 4);
            end
            if (i < 4) tick();
        end
        tick();
        #1;
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            errors++; $display("FAIL wbf_hold got stall%b req%b a%h exp stall1 req1 a00000040", stall, mem_req, mem_addr);
        end
        tick();
        mem_ack = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL wbf_ack_cycle_stall got %b exp 1", stall);
        end
        tick();
        mem_ack = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL wbf_freed_stall got %b exp 0", stall);
        end
        tick();
        memWrite = 1'b0; addr = '0; wdata = '0;
        mem_ack = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h44 + 4 * i || mem_wdata !== 32'hA1 + i) begin
                errors++; $display("FAIL wbf_drain%0d got req%b we%b a%h d%h exp req1 we1 a%h d%h",
                                   i, mem_req, mem_we, mem_addr, mem_wdata, 32'h44 + 4 * i, 32'hA1 + i);
            end
            tick();
        end
        mem_ack = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL wbf_empty got req %b exp 0", mem_req);
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] log_q [$];
        logic [32:0] exp_log [3] = '{{1'b1, 32'h10}, {1'b1, 32'h14}, {1'b0, 32'h20}};
        logic        got_read = 1'b0;
        int          stall_drops = 0;
        tick();
        memWrite = 1'b1; store = ST_SW; addr = 32'h10; wdata = 32'h1111_0010;
        tick();
        addr = 32'h14; wdata = 32'h1111_0014;
        tick();
        memWrite = 1'b0; memRead = 1'b1; load = LD_LW; addr = 32'h20; mem_rdata = 32'hCAFE_F00D;
        for (int unsigned i = 0; i < 20 && !got_read; i++) begin
            #1;
            if (stall !== 1'b1) stall_drops++;
            if (mem_req === 1'b1) begin
                log_q.push_back({mem_we, mem_addr});
                mem_ack = 1'b1;
                if (mem_we === 1'b0) got_read = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
            tick();
            mem_ack = 1'b0;
        end
        checks++;
        if (!got_read) begin
            errors++; $display("FAIL b2b_timeout got no read in 20 cycles exp read of 00000020");
        end
        checks++;
        if (stall_drops != 0) begin
            errors++; $display("FAIL b2b_stall_held got %0d low cycles exp 0", stall_drops);
        end
        checks++;
        if (log_q.size() != 3) begin
            errors++; $display("FAIL b2b_count got %0d accesses exp 3", log_q.size());
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                checks++;
                if (log_q[k] !== exp_log[k]) begin
                    errors++; $display("FAIL b2b_order%0d got we%b a%h exp we%b a%h",
                                       k, log_q[k][32], log_q[k][31:0], exp_log[k][32], exp_log[k][31:0]);
                end
            end
        end
        #1;
        checks++;
        if (stall !== 1'b0 || rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL b2b_ldone got stall%b rdata%h exp stall0 rdataCAFEF00D", stall, rdata);
        end
        tick();
        memRead = 1'b0; addr = '0;
    endtask

    task automatic test_errors();
        logic        rds [3] = '{1'b1, 1'b0, 1'b1};
        logic        wrs [3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0]  sts [3] = '{ST_SW, ST_SH, ST_SW};
        logic [31:0] as  [3] = '{32'h102, 32'h101, 32'h0};
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            memRead = rds[i]; memWrite = wrs[i]; load = LD_LW; store = sts[i]; addr = as[i]; wdata = 32'hDEAD_BEEF;
            #1;
            checks++;
            if ({stall, mem_req, lsu_err} !== 3'b000) begin
                errors++; $display("FAIL err%0d_req_cycle got stall%b req%b err%b exp 000", i, stall, mem_req, lsu_err);
            end
            tick();
            memRead = 1'b0; memWrite = 1'b0; addr = '0;
            #1;
            checks++;
            if ({lsu_err, mem_req} !== 2'b10 || rdata !== 32'hCAFE_F00D) begin
                errors++; $display("FAIL err%0d_pulse got err%b req%b rdata%h exp err1 req0 rdataCAFEF00D", i, lsu_err, mem_req, rdata);
            end
            tick();
            #1;
            checks++;
            if ({lsu_err, mem_req} !== 2'b00) begin
                errors++; $display("FAIL err%0d_after got err%b req%b exp 00", i, lsu_err, mem_req);
            end
        end
    endtask

    task automatic test_reset_mid();
        tick();
        memWrite = 1'b1; store = ST_SW; addr = 32'h60; wdata = 32'h6060_6060;
        tick();
        memWrite = 1'b0; addr = '0;
        #1;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rmid_write_pending got req %b exp 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL rmid_write_drop got req %b exp 0", mem_req);
        end
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL rmid_buffer_lost got req %b exp 0", mem_req);
        end
        tick();
        memRead = 1'b1; load = LD_LW; addr = 32'h70;
        tick();
        tick();
        #1;
        checks++;
        if ({mem_req, stall} !== 2'b11) begin
            errors++; $display("FAIL rmid_lwait got req%b stall%b exp 11", mem_req, stall);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, stall} !== 2'b00) begin
            errors++; $display("FAIL rmid_load_drop got req%b stall%b exp 00", mem_req, stall);
        end
        tick();
        memRead = 1'b0; addr = '0;
        rst_n = 1'b1;
        do_load(LD_LW, 32'h74, 32'h55AA_55AA, 32'h55AA_55AA);
    endtask

    initial begin
        rst_n = 1'b0; memRead = 1'b0; memWrite = 1'b0; load = LD_LW; store = ST_SW;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_store_sb();
        test_load_formats();
        test_wb_full();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
